// File: rtl/i2c_chunk_scheduler.sv
// i2c_chunk_scheduler
//   Drives the i2c_chunk engine behind the Marble QSFP readout. It issues a
//   one-cycle run_cmd pulse to start each I2C program pass and watches
//   run_stat with ack and run timeouts. It also lets a host debug master
//   borrow the 12-bit localbus between passes. While the host holds the
//   bus, freeze is asserted so the results seen by the readout stay
//   consistent.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   enable              allow periodic passes
//   host_req/host_gnt   host localbus request / grant
//   host_addr/din/write host localbus master
//   rd_addr             readout-path address (results region)
//   lb_addr/din/write   localbus toward i2c_chunk
//   run_cmd, freeze     control toward i2c_chunk
//   run_stat            pass-in-progress status from i2c_chunk
//   busy                pass in progress (START/ACK/RUN)
//   err_flag, err_clr   sticky timeout flag and its clear
//   pass_count          completed passes, wrapping 16-bit counter
module i2c_chunk_scheduler #(
    parameter int unsigned POLL_TICKS    = 50000000,
    parameter int unsigned ACK_TICKS     = 16,
    parameter int unsigned TIMEOUT_TICKS = 20000000,
    parameter int unsigned STARTUP_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        host_req,
    output logic        host_gnt,
    input  logic [11:0] host_addr,
    input  logic [7:0]  host_din,
    input  logic        host_write,
    input  logic [11:0] rd_addr,
    output logic [11:0] lb_addr,
    output logic [7:0]  lb_din,
    output logic        lb_write,
    output logic        run_cmd,
    output logic        freeze,
    input  logic        run_stat,
    output logic        busy,
    output logic        err_flag,
    input  logic        err_clr,
    output logic [15:0] pass_count
);

    localparam logic [31:0] POLL_LOAD    = 32'(POLL_TICKS - 1);
    localparam logic [31:0] ACK_LOAD     = 32'(ACK_TICKS - 1);
    localparam logic [31:0] RUN_LOAD     = 32'(TIMEOUT_TICKS - 1);
    localparam logic [31:0] STARTUP_LOAD = 32'(STARTUP_TICKS - 1);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_START,
        ST_ACK,
        ST_RUN,
        ST_HOST
    } state_t;

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic        err_set;
    logic        pass_inc;

    // One counter serves the poll, ack and run intervals. The poll count
    // only matters in WAIT/HOST and is reloaded whenever a pass ends. The
    // ack window is loaded on the way into START, so it also counts the
    // START cycle. That makes ACK_TICKS the limit measured from the run_cmd
    // pulse itself.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_set  = 1'b0;
        pass_inc = 1'b0;
        unique case (state)
            ST_WAIT: begin
                if (host_req) begin
                    state_nx = ST_HOST;
                end else if (enable) begin
                    if (cnt == '0) begin
                        state_nx = ST_START;
                        cnt_nx   = ACK_LOAD;
                    end else begin
                        cnt_nx = cnt - 32'd1;
                    end
                end
            end
            ST_START: begin
                state_nx = ST_ACK;
                cnt_nx   = cnt - 32'd1;
            end
            ST_ACK: begin
                if (run_stat) begin
                    state_nx = ST_RUN;
                    cnt_nx   = RUN_LOAD;
                end else if (cnt == '0) begin
                    err_set  = 1'b1;
                    state_nx = ST_WAIT;
                    cnt_nx   = POLL_LOAD;
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            ST_RUN: begin
                if (!run_stat) begin
                    pass_inc = 1'b1;
                    state_nx = ST_WAIT;
                    cnt_nx   = POLL_LOAD;
                end else if (cnt == '0) begin
                    err_set  = 1'b1;
                    state_nx = ST_WAIT;
                    cnt_nx   = POLL_LOAD;
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            ST_HOST: begin
                if (!host_req) state_nx = ST_WAIT;
            end
            default: begin
                state_nx = ST_WAIT;
                cnt_nx   = POLL_LOAD;
            end
        endcase
    end

    // Outputs are registered from the next state. They therefore change on
    // the same edge as the state: grant and freeze drop on the HOST->WAIT
    // edge, and run_cmd is high only while the state is START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WAIT;
            cnt        <= STARTUP_LOAD;
            run_cmd    <= 1'b0;
            host_gnt   <= 1'b0;
            freeze     <= 1'b0;
            busy       <= 1'b0;
            err_flag   <= 1'b0;
            pass_count <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            run_cmd  <= (state_nx == ST_START);
            host_gnt <= (state_nx == ST_HOST);
            freeze   <= (state_nx == ST_HOST);
            busy     <= (state_nx == ST_START) || (state_nx == ST_ACK) ||
                        (state_nx == ST_RUN);
            if (err_set) begin
                err_flag <= 1'b1;
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end
            if (pass_inc) begin
                pass_count <= pass_count + 16'd1;
            end
        end
    end

    assign lb_addr  = host_gnt ? host_addr : rd_addr;
    assign lb_din   = host_din;
    assign lb_write = host_write & host_gnt;

endmodule

// File: tb/tb_i2c_chunk_scheduler.sv
// Testbench for i2c_chunk_scheduler. A reference model gives the pass
// outcome and timing from the scheduling rules. The i2c_chunk engine is
// emulated by an activity window of run_stat placed relative to run_cmd.
module tb_i2c_chunk_scheduler;

    localparam int POLL    = 100;
    localparam int ACK     = 16;
    localparam int TMO     = 50;
    localparam int STARTUP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        host_req = 1'b0;
    logic        host_gnt;
    logic [11:0] host_addr = '0;
    logic [7:0]  host_din = '0;
    logic        host_write = 1'b0;
    logic [11:0] rd_addr = '0;
    logic [11:0] lb_addr;
    logic [7:0]  lb_din;
    logic        lb_write;
    logic        run_cmd;
    logic        freeze;
    logic        run_stat = 1'b0;
    logic        busy;
    logic        err_flag;
    logic        err_clr = 1'b0;
    logic [15:0] pass_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Emulated engine: the DUT sees run_stat high on edges g_e+g_d .. g_e+g_d+g_len-1.
    int g_e = 0;
    int g_d = 0;
    int g_len = 0;

    int          last_cmd = 0;
    int          last_end = 0;
    logic [15:0] exp_pass = '0;
    logic        exp_err = 1'b0;

    i2c_chunk_scheduler #(
        .POLL_TICKS(POLL),
        .ACK_TICKS(ACK),
        .TIMEOUT_TICKS(TMO),
        .STARTUP_TICKS(STARTUP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .host_req(host_req),
        .host_gnt(host_gnt),
        .host_addr(host_addr),
        .host_din(host_din),
        .host_write(host_write),
        .rd_addr(rd_addr),
        .lb_addr(lb_addr),
        .lb_din(lb_din),
        .lb_write(lb_write),
        .run_cmd(run_cmd),
        .freeze(freeze),
        .run_stat(run_stat),
        .busy(busy),
        .err_flag(err_flag),
        .err_clr(err_clr),
        .pass_count(pass_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pass outcome from the rules: the ack must arrive within ACK cycles of
    // run_cmd, and the run may last at most TMO cycles. Returns the cycle at
    // which the scheduler is back in WAIT.
    function automatic int pass_end(input int e, input int d, input int len, output bit ok);
        if (len == 0 || d > ACK) begin
            ok = 1'b0;
            return e + ACK;
        end
        if (len > TMO) begin
            ok = 1'b0;
            return e + d + TMO;
        end
        ok = 1'b1;
        return e + d + len;
    endfunction

    task automatic tick();
        run_stat = ((cyc + 1) >= (g_e + g_d)) && ((cyc + 1) < (g_e + g_d + g_len));
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_cmd(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (run_cmd === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0 && run_cmd === 1'b1) at = cyc;
    endtask

    task automatic test_reset();
        int at;
        int r;
        g_len = 0;
        rst_n = 1'b0;
        enable = 1'b1;
        rd_addr = 12'($urandom);
        repeat (3) tick();
        checks++; if (run_cmd !== 1'b0) begin errors++; $display("FAIL reset_run_cmd: got %b expected 0", run_cmd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (host_gnt !== 1'b0 || freeze !== 1'b0) begin errors++; $display("FAIL reset_gnt_freeze: got %b%b expected 00", host_gnt, freeze); end
        checks++; if (lb_write !== 1'b0) begin errors++; $display("FAIL reset_lb_write: got %b expected 0", lb_write); end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_flag); end
        checks++; if (pass_count !== 16'h0) begin errors++; $display("FAIL reset_pass_count: got %h expected 0", pass_count); end
        checks++; if (lb_addr !== rd_addr) begin errors++; $display("FAIL reset_lb_addr: got %h expected %h", lb_addr, rd_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        wait_cmd(STARTUP + 5, at);
        checks++; if (at !== r + STARTUP) begin errors++; $display("FAIL startup_run_cmd: got cycle %0d expected %0d", at, r + STARTUP); end
        last_cmd = at;
        exp_pass = '0;
        exp_err = 1'b0;
    endtask

    task automatic test_first_pass();
        int e, endc, at;
        bit ok;
        e = last_cmd;
        g_e = e; g_d = 3; g_len = 20;
        endc = pass_end(e, 3, 20, ok);
        tick();
        checks++; if (run_cmd !== 1'b0) begin errors++; $display("FAIL run_cmd_width: got %b expected 0", run_cmd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b expected 1", busy); end
        advance_to(endc - 1);
        checks++; if (pass_count !== 16'd0) begin errors++; $display("FAIL first_pass_early: got %0d expected 0", pass_count); end
        tick();
        exp_pass = 16'd1;
        checks++; if (pass_count !== exp_pass) begin errors++; $display("FAIL first_pass_count: got %0d expected %0d", pass_count, exp_pass); end
        checks++; if (busy !== 1'b0 || err_flag !== 1'b0) begin errors++; $display("FAIL first_pass_idle: got busy=%b err=%b expected 0 0", busy, err_flag); end
        last_end = endc;
        wait_cmd(POLL + 10, at);
        checks++; if (at !== last_end + POLL) begin errors++; $display("FAIL poll_interval: got cycle %0d expected %0d", at, last_end + POLL); end
        last_cmd = at;
    endtask

    task automatic test_ack_timeout();
        int e, e2, endc, at;
        bit ok;
        e = last_cmd;
        g_e = e; g_d = 1000; g_len = 0;
        endc = pass_end(e, 1000, 0, ok);
        advance_to(endc - 1);
        checks++; if (err_flag !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ack_early: got err=%b busy=%b expected 0 1", err_flag, busy); end
        tick();
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL ack_timeout_err: got %b expected 1", err_flag); end
        checks++; if (busy !== 1'b0 || pass_count !== exp_pass) begin errors++; $display("FAIL ack_timeout_state: got busy=%b pass=%0d expected 0 %0d", busy, pass_count, exp_pass); end
        last_end = endc;
        wait_cmd(POLL + 10, at);
        checks++; if (at !== last_end + POLL) begin errors++; $display("FAIL ack_retry: got cycle %0d expected %0d", at, last_end + POLL); end
        e2 = at;
        g_e = e2;
        advance_to(e2 + 2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL err_clr: got %b expected 0", err_flag); end
        advance_to(e2 + ACK - 1);
        err_clr = 1'b1;
        tick();
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b expected 1", err_flag); end
        tick();
        err_clr = 1'b0;
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL err_clr2: got %b expected 0", err_flag); end
        last_end = e2 + ACK;
        wait_cmd(POLL + 10, at);
        checks++; if (at !== last_end + POLL) begin errors++; $display("FAIL ack_retry2: got cycle %0d expected %0d", at, last_end + POLL); end
        last_cmd = at;
        exp_err = 1'b0;
    endtask

    task automatic test_run_timeout();
        int e, len, endc, at;
        bit ok;
        e = last_cmd;
        len = TMO + 1 + int'($urandom_range(0, 9));
        g_e = e; g_d = 3; g_len = len;
        endc = pass_end(e, 3, len, ok);
        advance_to(endc - 1);
        checks++; if (err_flag !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL run_early: got err=%b busy=%b expected 0 1", err_flag, busy); end
        tick();
        checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL run_timeout_err: got %b expected 1", err_flag); end
        checks++; if (pass_count !== exp_pass || busy !== 1'b0) begin errors++; $display("FAIL run_timeout_state: got pass=%0d busy=%b expected %0d 0", pass_count, busy, exp_pass); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        last_end = endc;
        wait_cmd(POLL + 10, at);
        checks++; if (at !== last_end + POLL) begin errors++; $display("FAIL run_timeout_retry: got cycle %0d expected %0d", at, last_end + POLL); end
        last_cmd = at;
    endtask

    task automatic test_random_passes();
        int e, d, len, endc, at;
        bit ok;
        for (int k = 0; k < 8; k++) begin
            e = last_cmd;
            d = int'($urandom_range(2, ACK + 3));
            len = int'($urandom_range(1, TMO + 8));
            g_e = e; g_d = d; g_len = len;
            endc = pass_end(e, d, len, ok);
            if (ok) exp_pass = exp_pass + 16'd1;
            else exp_err = 1'b1;
            advance_to(endc - 1);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected 1", k, busy); end
            tick();
            checks++; if (pass_count !== exp_pass || err_flag !== exp_err || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_outcome[%0d] d=%0d len=%0d: got pass=%0d err=%b busy=%b expected %0d %b 0",
                         k, d, len, pass_count, err_flag, busy, exp_pass, exp_err);
            end
            last_end = endc;
            wait_cmd(POLL + 10, at);
            checks++; if (at !== last_end + POLL) begin errors++; $display("FAIL rand_next[%0d]: got cycle %0d expected %0d", k, at, last_end + POLL); end
            last_cmd = at;
        end
    endtask

    task automatic test_host_during_run();
        int e, endc, at, n, bad;
        bit ok;
        e = last_cmd;
        g_e = e; g_d = 3; g_len = 20;
        endc = pass_end(e, 3, 20, ok);
        advance_to(e + 5);
        host_req = 1'b1;
        host_write = 1'b1;
        host_addr = 12'h3FF;
        bad = 0;
        while (cyc < endc) begin
            if (host_gnt !== 1'b0 || freeze !== 1'b0 || lb_write !== 1'b0) bad++;
            tick();
        end
        if (host_gnt !== 1'b0 || lb_write !== 1'b0) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL host_pre_grant: got %0d granted/written cycles expected 0", bad); end
        exp_pass = exp_pass + 16'd1;
        tick();
        checks++; if (host_gnt !== 1'b1 || freeze !== 1'b1) begin errors++; $display("FAIL host_grant: got gnt=%b freeze=%b expected 1 1", host_gnt, freeze); end
        host_addr = 12'h010;
        host_din = 8'hA5;
        #1;
        checks++; if (lb_write !== 1'b1 || lb_addr !== 12'h010 || lb_din !== 8'hA5) begin
            errors++;
            $display("FAIL host_write: got we=%b addr=%h din=%h expected 1 010 a5", lb_write, lb_addr, lb_din);
        end
        host_write = 1'b0;
        #1;
        checks++; if (lb_write !== 1'b0) begin errors++; $display("FAIL host_write_off: got %b expected 0", lb_write); end
        n = int'($urandom_range(5, 20));
        advance_to(endc + 1 + n - 1);
        host_req = 1'b0;
        tick();
        checks++; if (host_gnt !== 1'b0 || freeze !== 1'b0 || lb_addr !== rd_addr) begin
            errors++;
            $display("FAIL host_release: got gnt=%b freeze=%b addr=%h expected 0 0 %h", host_gnt, freeze, lb_addr, rd_addr);
        end
        wait_cmd(POLL + 10, at);
        checks++; if (at !== endc + POLL + n + 1) begin errors++; $display("FAIL host_delayed_poll: got cycle %0d expected %0d", at, endc + POLL + n + 1); end
        last_cmd = at;
    endtask

    task automatic test_host_expiry();
        int e, endc, at, h, n, seen;
        bit ok;
        e = last_cmd;
        g_e = e; g_d = 2; g_len = 5;
        endc = pass_end(e, 2, 5, ok);
        advance_to(endc);
        exp_pass = exp_pass + 16'd1;
        rd_addr = 12'h8C0;
        host_addr = 12'($urandom_range(0, 12'h7FF));
        h = endc + POLL;
        advance_to(h - 1);
        checks++; if (lb_addr !== 12'h8C0) begin errors++; $display("FAIL rd_addr_mux: got %h expected 8c0", lb_addr); end
        host_req = 1'b1;
        tick();
        checks++; if (host_gnt !== 1'b1 || freeze !== 1'b1 || lb_addr !== host_addr) begin
            errors++;
            $display("FAIL expiry_grant: got gnt=%b freeze=%b addr=%h expected 1 1 %h", host_gnt, freeze, lb_addr, host_addr);
        end
        n = int'($urandom_range(3, 15));
        seen = 0;
        while (cyc < h + n - 1) begin
            if (run_cmd !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        if (run_cmd !== 1'b0) seen++;
        checks++; if (seen !== 0) begin errors++; $display("FAIL expiry_no_cmd: got %0d active cycles expected 0", seen); end
        host_req = 1'b0;
        tick();
        checks++; if (host_gnt !== 1'b0 || run_cmd !== 1'b0 || lb_addr !== 12'h8C0) begin
            errors++;
            $display("FAIL expiry_release: got gnt=%b cmd=%b addr=%h expected 0 0 8c0", host_gnt, run_cmd, lb_addr);
        end
        wait_cmd(4, at);
        checks++; if (at !== h + n + 1) begin errors++; $display("FAIL expiry_cmd: got cycle %0d expected %0d", at, h + n + 1); end
        last_cmd = at;
    endtask

    task automatic test_enable();
        int e, endc, at, x, pulses;
        bit ok;
        e = last_cmd;
        g_e = e; g_d = 4; g_len = 10;
        endc = pass_end(e, 4, 10, ok);
        advance_to(e + 5);
        enable = 1'b0;
        advance_to(endc);
        exp_pass = exp_pass + 16'd1;
        checks++; if (pass_count !== exp_pass || busy !== 1'b0) begin errors++; $display("FAIL enable_pass_done: got pass=%0d busy=%b expected %0d 0", pass_count, busy, exp_pass); end
        pulses = 0;
        repeat (1000) begin
            tick();
            if (run_cmd !== 1'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL disabled_cmd: got %0d pulses expected 0", pulses); end
        enable = 1'b1;
        x = cyc;
        wait_cmd(POLL + 10, at);
        checks++; if (at !== x + POLL) begin errors++; $display("FAIL reenable_cmd: got cycle %0d expected %0d", at, x + POLL); end
        last_cmd = at;
    endtask

    task automatic test_reset_mid_run();
        int e, at, r;
        e = last_cmd;
        g_e = e; g_d = 3; g_len = 30;
        advance_to(e + 10);
        rst_n = 1'b0;
        g_len = 0;
        run_stat = 1'b0;
        #1;
        checks++; if (run_cmd !== 1'b0 || busy !== 1'b0 || host_gnt !== 1'b0 || freeze !== 1'b0 || lb_write !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_ctrl: got cmd=%b busy=%b gnt=%b frz=%b we=%b expected 0", run_cmd, busy, host_gnt, freeze, lb_write);
        end
        checks++; if (pass_count !== 16'h0 || err_flag !== 1'b0) begin errors++; $display("FAIL midrun_reset_regs: got pass=%0d err=%b expected 0 0", pass_count, err_flag); end
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        wait_cmd(STARTUP + 5, at);
        checks++; if (at !== r + STARTUP) begin errors++; $display("FAIL midrun_restart: got cycle %0d expected %0d", at, r + STARTUP); end
        last_cmd = at;
        exp_pass = '0;
        exp_err = 1'b0;
    endtask

    task automatic test_wrap();
        int e, endc, at;
        bit ok;
        e = last_cmd;
        g_e = e; g_d = 2; g_len = 3;
        endc = pass_end(e, 2, 3, ok);
        force dut.pass_count = 16'hFFFE;
        tick();
        release dut.pass_count;
        advance_to(endc);
        checks++; if (pass_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h expected ffff", pass_count); end
        wait_cmd(POLL + 10, at);
        e = at;
        g_e = e;
        endc = pass_end(e, 2, 3, ok);
        advance_to(endc);
        checks++; if (pass_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", pass_count); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_pass();
        test_ack_timeout();
        test_run_timeout();
        test_random_passes();
        test_host_during_run();
        test_host_expiry();
        test_enable();
        test_reset_mid_run();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
